burst_ram_arbiter: RTL and testbench
====================================

// Module: burst_ram_arbiter
// PURPOSE
//  Shares one BurstRAM port between two cache requesters: p0 = instruction cache,
//  p1 = data cache. Grants whole burst transactions with round-robin fairness,
//  muxes cmd/addr/wr_data/mask to the RAM and steers read beats to the owner.
//  Sits between the cache pair and BurstRAM; replaces ad-hoc enable muxing.
// PARAMETERS
//  RAM_DEPTH_BITWIDTH       4   burst address width
//  RAM_BURST_DATA_COUNT     4   beats per burst, read or write; >=2, power of 2
//  RAM_BURST_DATA_BITWIDTH  64  beat width
// PORTS
//  clk            in   1    clock
//  rst            in   1    reset: synchronous, active-high
//  pN_cmd         in   1    N=0,1: 0=read, 1=write
//  pN_cmd_en      in   1    request; held high until accepted
//  pN_addr        in   RAM_DEPTH_BITWIDTH        burst address
//  pN_wr_data     in   RAM_BURST_DATA_BITWIDTH   write beat
//  pN_data_mask   in   RAM_BURST_DATA_BITWIDTH/8 byte mask (1=masked)
//  pN_rd_data     out  RAM_BURST_DATA_BITWIDTH   = br_rd_data (broadcast)
//  pN_rd_data_valid out 1   br_rd_data_valid gated to the owner
//  pN_busy        out  1    request cannot be accepted this cycle
//  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask   out  to BurstRAM
//  br_rd_data, br_rd_data_valid, br_busy                  in   from BurstRAM
// BEHAVIOUR
//  States: IDLE, READ, WRITE, DRAIN. Regs: owner, last_grant, beat_cnt.
//  Reset: state=IDLE, owner=0, last_grant=1 (p0 wins first tie), beat_cnt=0.
//   Reset during a burst drops it; in-flight RAM beats go to no port.
//  IDLE, br_busy=0: winner = sole requester; if both, !last_grant.
//   Accept is combinational, same cycle: br_* = winner's signals,
//   br_cmd_en=1; owner<=winner, last_grant<=winner, beat_cnt<=0.
//   ->READ if cmd=0; ->WRITE if cmd=1 (that cycle is write beat 0).
//  pN_busy = (state!=IDLE) | br_busy | (other port wins in IDLE).
//   Accept of pN occurs iff pN_cmd_en & !pN_busy. No comb loop: busy_N
//   depends only on cmd_en of the other port.
//  br_cmd_en=0 outside the IDLE accept cycle. br_wr_data/br_data_mask/
//   br_addr/br_cmd follow owner in READ/WRITE/DRAIN, winner in IDLE
//   (p0 when none).
//  READ: pN_rd_data_valid = br_rd_data_valid & (owner==N), else 0.
//   beat_cnt++ per valid; on last beat (COUNT-1) -> IDLE next cycle.
//   Valid while IDLE (stray) forwarded to nobody.
//  WRITE: owner supplies beat k in the k-th cycle after accept;
//   beat_cnt++ every cycle; after beat COUNT-1 -> DRAIN.
//  DRAIN: wait br_busy=0, then IDLE (1 cycle min).
//  Round-robin: after a p0 burst a pending p1 wins, and vice versa;
//   single requester may be granted back-to-back.
//  Min re-grant gap: IDLE reached cycle after last read beat.
//  beat_cnt width clog2(COUNT); wraps to 0 on burst end.
// TESTING
//  1 p0 read addr=3 alone -> br_cmd_en 1 cycle, br_addr=3; 4 valids
//    reach p0 only; p1_rd_data_valid stays 0; p0_busy low after.
//  2 p0 & p1 read same cycle after reset -> p0 granted, p1_busy=1;
//    after p0's 4th beat p1 granted next IDLE cycle.
//  3 p1 write addr=5, beats 0x11..0x44, mask 0x0F -> br_cmd=1, 4 beats in
//    consecutive cycles, DRAIN until br_busy=0, then IDLE.
//  4 p0 requests continuously, p1 joins mid-burst -> grants alternate
//    p0,p1,p0; no starvation over 6 bursts.
//  5 br_busy=1 with request pending -> no br_cmd_en, busy high; accept
//    first cycle br_busy falls.
//  6 rst asserted mid-read after 2 beats -> IDLE next cycle, remaining
//    beats not forwarded, p0 wins next tie.

Source files
------------

// File: rtl/burst_ram_arbiter.sv
// Two-port burst arbiter in front of a single BurstRAM port.
// p0 (instruction cache) and p1 (data cache) are granted whole bursts with
// round-robin fairness; command signals are muxed to the RAM and read beats
// are steered to whichever port owns the current burst.
module burst_ram_arbiter #(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_COUNT    = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic                                   p0_cmd_i,
    input  logic                                   p0_cmd_en_i,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]          p0_addr_i,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     p0_wr_data_i,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   p0_data_mask_i,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]     p0_rd_data_o,
    output logic                                   p0_rd_data_valid_o,
    output logic                                   p0_busy_o,

    input  logic                                   p1_cmd_i,
    input  logic                                   p1_cmd_en_i,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]          p1_addr_i,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     p1_wr_data_i,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   p1_data_mask_i,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]     p1_rd_data_o,
    output logic                                   p1_rd_data_valid_o,
    output logic                                   p1_busy_o,

    output logic                                   br_cmd_o,
    output logic                                   br_cmd_en_o,
    output logic [RAM_DEPTH_BITWIDTH-1:0]          br_addr_o,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_wr_data_o,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   br_data_mask_o,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_rd_data_i,
    input  logic                                   br_rd_data_valid_i,
    input  logic                                   br_busy_i
);

    localparam int BW = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
    localparam logic [BW-1:0] RD_LAST = BW'(RAM_BURST_DATA_COUNT - 1);
    // Write beat 0 goes out in the accept cycle, so the WRITE state only
    // covers beats 1..COUNT-1; beat_cnt counts those cycles from 0.
    localparam logic [BW-1:0] WR_LAST = BW'(RAM_BURST_DATA_COUNT - 2);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_t;

    state_t          state_q;
    logic            owner_q;
    logic            last_grant_q;
    logic [BW-1:0]   beat_cnt_q;

    logic            idle;
    logic            p0_wins_tie;
    logic            accept0;
    logic            accept1;
    logic            sel;

    // Busy/accept decode: each busy only looks at the other port's request,
    // so a requester's cmd_en never feeds back into its own busy.
    always_comb begin
        idle        = (state_q == IDLE);
        p0_wins_tie = last_grant_q;
        p0_busy_o   = !idle | br_busy_i | (p1_cmd_en_i & !p0_wins_tie);
        p1_busy_o   = !idle | br_busy_i | (p0_cmd_en_i &  p0_wins_tie);
        accept0     = p0_cmd_en_i & !p0_busy_o;
        accept1     = p1_cmd_en_i & !p1_busy_o;
        br_cmd_en_o = accept0 | accept1;
        if (idle)
            sel = p1_cmd_en_i & (!p0_cmd_en_i | !p0_wins_tie);
        else
            sel = owner_q;
    end

    // RAM-side mux and read-beat steering.
    always_comb begin
        br_cmd_o           = sel ? p1_cmd_i       : p0_cmd_i;
        br_addr_o          = sel ? p1_addr_i      : p0_addr_i;
        br_wr_data_o       = sel ? p1_wr_data_i   : p0_wr_data_i;
        br_data_mask_o     = sel ? p1_data_mask_i : p0_data_mask_i;
        p0_rd_data_o       = br_rd_data_i;
        p1_rd_data_o       = br_rd_data_i;
        p0_rd_data_valid_o = br_rd_data_valid_i & (state_q == READ) & !owner_q;
        p1_rd_data_valid_o = br_rd_data_valid_i & (state_q == READ) &  owner_q;
    end

    // Burst sequencing FSM: grant, count beats, drain, return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept0 | accept1) begin
                        owner_q      <= accept1;
                        last_grant_q <= accept1;
                        beat_cnt_q   <= '0;
                        state_q      <= br_cmd_o ? WRITE : READ;
                    end
                end
                READ: begin
                    if (br_rd_data_valid_i) begin
                        beat_cnt_q <= beat_cnt_q + BW'(1);
                        if (beat_cnt_q == RD_LAST)
                            state_q <= IDLE;
                    end
                end
                WRITE: begin
                    if (beat_cnt_q == WR_LAST) begin
                        beat_cnt_q <= '0;
                        state_q    <= DRAIN;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + BW'(1);
                    end
                end
                DRAIN: begin
                    if (!br_busy_i)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: single reads, ties, writes with
// drain, RAM back-pressure, round-robin alternation and mid-burst reset.
module tb_burst_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_cmd, p0_cmd_en, p1_cmd, p1_cmd_en;
    logic [3:0]  p0_addr, p1_addr;
    logic [63:0] p0_wr_data, p1_wr_data;
    logic [7:0]  p0_data_mask, p1_data_mask;
    logic [63:0] p0_rd_data, p1_rd_data;
    logic        p0_rd_data_valid, p1_rd_data_valid, p0_busy, p1_busy;
    logic        br_cmd, br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid, br_busy;

    int checks = 0;
    int errors = 0;

    burst_ram_arbiter #(
        .RAM_DEPTH_BITWIDTH(4),
        .RAM_BURST_DATA_COUNT(4),
        .RAM_BURST_DATA_BITWIDTH(64)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_cmd_i(p0_cmd), .p0_cmd_en_i(p0_cmd_en), .p0_addr_i(p0_addr),
        .p0_wr_data_i(p0_wr_data), .p0_data_mask_i(p0_data_mask),
        .p0_rd_data_o(p0_rd_data), .p0_rd_data_valid_o(p0_rd_data_valid), .p0_busy_o(p0_busy),
        .p1_cmd_i(p1_cmd), .p1_cmd_en_i(p1_cmd_en), .p1_addr_i(p1_addr),
        .p1_wr_data_i(p1_wr_data), .p1_data_mask_i(p1_data_mask),
        .p1_rd_data_o(p1_rd_data), .p1_rd_data_valid_o(p1_rd_data_valid), .p1_busy_o(p1_busy),
        .br_cmd_o(br_cmd), .br_cmd_en_o(br_cmd_en), .br_addr_o(br_addr),
        .br_wr_data_o(br_wr_data), .br_data_mask_o(br_data_mask),
        .br_rd_data_i(br_rd_data), .br_rd_data_valid_i(br_rd_data_valid), .br_busy_i(br_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 unit after that, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed four read beats and check they reach only the owning port.
    task automatic read_beats(input int own, input string tag);
        for (int b = 0; b < 4; b++) begin
            br_rd_data       = 64'hA000 + 64'(own * 16 + b);
            br_rd_data_valid = 1'b1;
            #1;
            check({tag, "_p0_valid"}, p0_rd_data_valid, (own == 0));
            check({tag, "_p1_valid"}, p1_rd_data_valid, (own == 1));
            check({tag, "_rd_data"}, (own == 0) ? p0_rd_data : p1_rd_data, 64'hA000 + 64'(own * 16 + b));
            tick();
        end
        br_rd_data_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        p0_cmd = 0; p0_cmd_en = 0; p0_addr = 0; p0_wr_data = 0; p0_data_mask = 0;
        p1_cmd = 0; p1_cmd_en = 0; p1_addr = 0; p1_wr_data = 0; p1_data_mask = 0;
        br_rd_data = 0; br_rd_data_valid = 0; br_busy = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_p0_busy", p0_busy, 1'b0);
        check("rst_p1_busy", p1_busy, 1'b0);
        check("rst_cmd_en", br_cmd_en, 1'b0);

        // 1: p0 read addr 3 alone
        p0_cmd_en = 1; p0_cmd = 0; p0_addr = 4'd3;
        #1;
        check("t1_cmd_en", br_cmd_en, 1'b1);
        check("t1_addr", br_addr, 4'd3);
        check("t1_cmd", br_cmd, 1'b0);
        tick();
        p0_cmd_en = 0;
        #1;
        check("t1_cmd_en_off", br_cmd_en, 1'b0);
        check("t1_busy_in_read", p0_busy, 1'b1);
        read_beats(0, "t1");
        #1;
        check("t1_busy_after", p0_busy, 1'b0);
        br_rd_data_valid = 1;
        #1;
        check("stray_p0_valid", p0_rd_data_valid, 1'b0);
        check("stray_p1_valid", p1_rd_data_valid, 1'b0);
        tick();
        br_rd_data_valid = 0;

        // 2: tie straight after reset, p0 wins, p1 follows
        rst = 1; tick(); rst = 0;
        p0_cmd_en = 1; p0_addr = 4'd1; p1_cmd_en = 1; p1_cmd = 0; p1_addr = 4'd2;
        #1;
        check("t2_cmd_en", br_cmd_en, 1'b1);
        check("t2_addr_p0", br_addr, 4'd1);
        check("t2_p0_busy", p0_busy, 1'b0);
        check("t2_p1_busy", p1_busy, 1'b1);
        tick();
        p0_cmd_en = 0;
        #1;
        check("t2_p1_busy_read", p1_busy, 1'b1);
        read_beats(0, "t2a");
        #1;
        check("t2_p1_grant", br_cmd_en, 1'b1);
        check("t2_addr_p1", br_addr, 4'd2);
        check("t2_p1_busy_idle", p1_busy, 1'b0);
        tick();
        p1_cmd_en = 0;
        read_beats(1, "t2b");

        // 3: p1 write addr 5, four beats, then drain on br_busy
        p1_cmd = 1; p1_cmd_en = 1; p1_addr = 4'd5; p1_wr_data = 64'h11; p1_data_mask = 8'h0F;
        #1;
        check("t3_cmd_en", br_cmd_en, 1'b1);
        check("t3_cmd", br_cmd, 1'b1);
        check("t3_addr", br_addr, 4'd5);
        check("t3_beat0", br_wr_data, 64'h11);
        check("t3_mask", br_data_mask, 8'h0F);
        tick();
        p1_cmd_en = 0;
        for (int k = 1; k < 4; k++) begin
            p1_wr_data = 64'(k + 1) * 64'h11;
            #1;
            check("t3_beat", br_wr_data, 64'(k + 1) * 64'h11);
            check("t3_no_cmd_en", br_cmd_en, 1'b0);
            check("t3_p1_busy", p1_busy, 1'b1);
            tick();
        end
        br_busy = 1;
        #1;
        check("t3_drain_busy", p1_busy, 1'b1);
        tick();
        br_busy = 0;
        #1;
        check("t3_drain_hold", p1_busy, 1'b1);
        tick();
        check("t3_idle_p0", p0_busy, 1'b0);
        check("t3_idle_p1", p1_busy, 1'b0);
        p1_cmd = 0;

        // 5: RAM busy holds off a pending request
        br_busy = 1; p0_cmd_en = 1; p0_addr = 4'd7;
        #1;
        check("t5_no_cmd_en", br_cmd_en, 1'b0);
        check("t5_p0_busy", p0_busy, 1'b1);
        tick();
        check("t5_still_off", br_cmd_en, 1'b0);
        br_busy = 0;
        #1;
        check("t5_accept", br_cmd_en, 1'b1);
        check("t5_addr", br_addr, 4'd7);
        tick();
        p0_cmd_en = 0;
        read_beats(0, "t5");

        // 4: p0 requests continuously, p1 joins mid-burst; six alternating grants
        p0_cmd_en = 1; p0_addr = 4'd8; p1_addr = 4'd9;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t4_grant", br_cmd_en, 1'b1);
            check("t4_addr", br_addr, (i % 2 == 0) ? 4'd8 : 4'd9);
            check("t4_winner_busy", (i % 2 == 0) ? p0_busy : p1_busy, 1'b0);
            if (i > 0)
                check("t4_loser_busy", (i % 2 == 0) ? p1_busy : p0_busy, 1'b1);
            tick();
            if (i == 0) p1_cmd_en = 1;
            if (i == 5) begin p0_cmd_en = 0; p1_cmd_en = 0; end
            read_beats(i % 2, "t4");
        end

        // 6: reset after two beats of a p0 read
        p0_cmd_en = 1; p0_addr = 4'd4;
        #1;
        check("t6_grant", br_cmd_en, 1'b1);
        tick();
        p0_cmd_en = 0;
        for (int b = 0; b < 2; b++) begin
            br_rd_data_valid = 1;
            #1;
            check("t6_beat_valid", p0_rd_data_valid, 1'b1);
            tick();
        end
        br_rd_data_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        br_rd_data_valid = 1;
        #1;
        check("t6_drop_p0", p0_rd_data_valid, 1'b0);
        check("t6_drop_p1", p1_rd_data_valid, 1'b0);
        check("t6_idle", p0_busy, 1'b0);
        tick();
        br_rd_data_valid = 0;
        p0_cmd_en = 1; p1_cmd_en = 1; p0_addr = 4'd6; p1_addr = 4'd10;
        #1;
        check("t6_tie_addr", br_addr, 4'd6);
        check("t6_tie_p0_busy", p0_busy, 1'b0);
        check("t6_tie_p1_busy", p1_busy, 1'b1);
        tick();
        p0_cmd_en = 0; p1_cmd_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
